// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one variable-latency memory port among CORE_COUNT cores.
// One transaction in flight; outputs come from registers or state decode only.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
module mem_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int REG_SIZE   = `REG_SIZE,
    parameter int ADDR_SIZE  = `ADDR_SIZE,
    parameter int GRANT_W    = $clog2(CORE_COUNT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*CORE_COUNT-1:0]          core_enable,
    input  logic [ADDR_SIZE*CORE_COUNT-1:0]  core_addr,
    input  logic [REG_SIZE*CORE_COUNT-1:0]   core_wr_data,
    output logic [REG_SIZE-1:0]              core_rd_data,
    output logic [CORE_COUNT-1:0]            core_ready_sig,
    output logic [1:0]                       mem_enable,
    output logic [ADDR_SIZE-1:0]             mem_addr,
    output logic [REG_SIZE-1:0]              mem_wr_data,
    input  logic [REG_SIZE-1:0]              mem_rd_data,
    input  logic                             mem_ack,
    output logic                             err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   last_q, last_d, grant_q, grant_d, pick;
    logic [1:0]           op_q, op_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [REG_SIZE-1:0]  wdata_q, wdata_d, rd_buf_q, rd_buf_d;
    logic                 err_q, err_d, hit;
    logic [CORE_COUNT-1:0] req, bad;

    // 01/10 are requests (odd parity); 11 is flagged but never served
    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_slot
        assign req[i] = ^core_enable[2*i +: 2];
        assign bad[i] = &core_enable[2*i +: 2];
    end

    always_comb begin
        hit  = 1'b0;
        pick = last_q;
        for (int k = 1; k <= CORE_COUNT; k++) begin
            if (!hit && req[GRANT_W'((int'(last_q) + k) % CORE_COUNT)]) begin
                hit  = 1'b1;
                pick = GRANT_W'((int'(last_q) + k) % CORE_COUNT);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_buf_d = rd_buf_q;
        err_d    = err_q | (|bad);
        case (state_q)
            IDLE: if (hit) begin
                grant_d = pick;
                op_d    = core_enable[2*pick +: 2];
                addr_d  = core_addr[ADDR_SIZE*pick +: ADDR_SIZE];
                wdata_d = core_wr_data[REG_SIZE*pick +: REG_SIZE];
                state_d = BUSY;
            end
            BUSY: if (mem_ack) begin
                rd_buf_d = (op_q == 2'b01) ? mem_rd_data : rd_buf_q;
                state_d  = RESP;
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= GRANT_W'(CORE_COUNT - 1);
            grant_q  <= '0;
            op_q     <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_buf_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
            err_q    <= err_d;
        end
    end

    assign mem_enable     = (state_q == BUSY) ? op_q : 2'b00;
    assign mem_addr       = addr_q;
    assign mem_wr_data    = wdata_q;
    assign core_rd_data   = rd_buf_q;
    assign core_ready_sig = (state_q == RESP) ? CORE_COUNT'(1) << grant_q : '0;
    assign err            = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    localparam int CC = 4, RW = 8, AW = 10;
    logic clk = 1'b0, reset = 1'b0;
    logic [2*CC-1:0]  core_enable = '0;
    logic [AW*CC-1:0] core_addr = '0;
    logic [RW*CC-1:0] core_wr_data = '0;
    logic [RW-1:0]    core_rd_data, mem_wr_data;
    logic [RW-1:0]    mem_rd_data = '0;
    logic [CC-1:0]    core_ready_sig;
    logic [1:0]       mem_enable;
    logic [AW-1:0]    mem_addr;
    logic             mem_ack = 1'b0, err;
    int checks = 0, errors = 0, ack_delay = 0, wcnt = 0, last = 3;
    bit auto_mem = 1'b1, man_ack = 1'b0;
    logic [RW-1:0] man_data = '0, rd_exp = '0;
    logic [RW-1:0] mem[1024], ref_mem[1024];

    mem_arbiter #(.CORE_COUNT(CC), .REG_SIZE(RW), .ADDR_SIZE(AW)) dut (
        .clk(clk), .reset(reset), .core_enable(core_enable), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_rd_data(core_rd_data), .core_ready_sig(core_ready_sig),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_ack(mem_ack), .err(err)
    );

    initial forever #5 clk = ~clk;

    // Memory: acks after ack_delay wait cycles of a nonzero mem_enable, or replays a manual ack
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = RW'($urandom);
        mem[10'h155] = 8'hA7;
        forever begin
            @(negedge clk);
            if (!auto_mem) begin
                mem_ack = man_ack;
                mem_rd_data = man_data;
            end else begin
                mem_ack = 1'b0;
                if (mem_enable != 2'b00) begin
                    if (wcnt == ack_delay) begin
                        mem_ack = 1'b1;
                        wcnt = 0;
                        if (mem_enable == 2'b01) mem_rd_data = mem[mem_addr];
                        else begin
                            mem[mem_addr] = mem_wr_data;
                            mem_rd_data = RW'($urandom);
                        end
                    end else wcnt++;
                end else wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [1:0] op, input logic [AW-1:0] a, input logic [RW-1:0] d);
        core_enable[2*s +: 2] = op;
        core_addr[AW*s +: AW] = a;
        core_wr_data[RW*s +: RW] = d;
    endtask

    task automatic scramble;
        for (int s = 0; s < CC; s++) set_slot(s, 2'($urandom_range(0, 2)), AW'($urandom), RW'($urandom));
    endtask

    task automatic do_reset;
        reset = 1'b0;
        core_enable = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick;
        last = 3;
        rd_exp = '0;
    endtask

    // Reference arbitration: first requester after the last grant, wrapping
    function automatic int rr(input logic [CC-1:0] r, input int lg);
        for (int k = 1; k <= CC; k++) begin
            int j = (lg + k) % CC;
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    initial begin
        int n, w;
        logic [CC-1:0] prev, reqv;
        logic [1:0] op;
        logic [AW-1:0] a;
        logic [RW-1:0] d;
        logic [1:0] en6[5];
        logic [CC-1:0] rd6[5];
        #1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        tick;
        chk("rst_en", mem_enable, 2'b00);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr", mem_wr_data, 0);
        chk("rst_rdy", core_ready_sig, 0);
        chk("rst_rd", core_rd_data, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        tick;
        // single load, zero wait
        ack_delay = 0;
        set_slot(2, 2'b01, 10'h155, 8'h00);
        tick;
        chk("t1_en", mem_enable, 2'b01);
        chk("t1_addr", mem_addr, 10'h155);
        chk("t1_rdy0", core_ready_sig, 0);
        tick;
        chk("t1_rdy", core_ready_sig, 4'b0100);
        chk("t1_rd", core_rd_data, 8'hA7);
        rd_exp = 8'hA7;
        set_slot(2, 2'b00, 0, 0);
        tick;
        chk("t1_idle", mem_enable, 2'b00);
        // store with three wait cycles
        ack_delay = 3;
        set_slot(0, 2'b10, 10'h003, 8'h5C);
        for (int j = 0; j < 4; j++) begin
            tick;
            chk("t2_en", mem_enable, 2'b10);
            chk("t2_wr", mem_wr_data, 8'h5C);
            chk("t2_rdy0", core_ready_sig, 0);
        end
        tick;
        chk("t2_rdy", core_ready_sig, 4'b0001);
        chk("t2_rd", core_rd_data, rd_exp);
        chk("t2_mem", mem[3], 8'h5C);
        ref_mem[3] = 8'h5C;
        set_slot(0, 2'b00, 0, 0);
        tick;
        // same slot back-to-back: IDLE cycle between transactions
        ack_delay = 0;
        en6 = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        rd6 = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        set_slot(0, 2'b01, 10'h010, 8'h00);
        for (int j = 0; j < 5; j++) begin
            tick;
            chk("t6_en", mem_enable, en6[j]);
            chk("t6_rdy", core_ready_sig, rd6[j]);
        end
        chk("t6_rd", core_rd_data, ref_mem[10'h010]);
        set_slot(0, 2'b00, 0, 0);
        tick;
        chk("t6_end_en", mem_enable, 2'b00);
        tick;
        chk("t6_end_en2", mem_enable, 2'b00);
        // fairness with all slots loading continuously
        do_reset;
        ack_delay = 1;
        for (int s = 0; s < CC; s++) set_slot(s, 2'b01, AW'(100 + s), 8'h00);
        n = 0;
        prev = '0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            tick;
            if (core_ready_sig != 0) begin
                w = rr('1, last);
                chk("t3_grant", core_ready_sig, 64'(1) << w);
                chk("t3_pulse", prev, 0);
                chk("t3_rd", core_rd_data, ref_mem[100 + w]);
                last = w;
                n++;
            end
            prev = core_ready_sig;
        end
        chk("t3_count", n, 5);
        core_enable = '0;
        tick;
        tick;
        // reset while BUSY, late ack ignored
        auto_mem = 1'b0;
        set_slot(1, 2'b01, 10'h020, 8'h00);
        tick;
        chk("t4_en", mem_enable, 2'b01);
        #2;
        reset = 1'b0;
        core_enable = '0;
        #1;
        chk("t4_en0", mem_enable, 2'b00);
        chk("t4_addr0", mem_addr, 0);
        chk("t4_wr0", mem_wr_data, 0);
        chk("t4_rdy0", core_ready_sig, 0);
        chk("t4_rd0", core_rd_data, 0);
        chk("t4_err0", err, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick;
        man_ack = 1'b1;
        man_data = 8'h3C;
        tick;
        man_ack = 1'b0;
        tick;
        chk("t4_late_rdy", core_ready_sig, 0);
        chk("t4_late_en", mem_enable, 2'b00);
        chk("t4_late_rd", core_rd_data, 0);
        tick;
        chk("t4_late_rdy2", core_ready_sig, 0);
        auto_mem = 1'b1;
        last = 3;
        rd_exp = '0;
        // illegal enable on slot 3 while slot 1 loads
        ack_delay = 1;
        set_slot(3, 2'b11, 10'h3FF, 8'hFF);
        set_slot(1, 2'b01, 10'h030, 8'h00);
        tick;
        chk("t5_err", err, 1);
        chk("t5_en", mem_enable, 2'b01);
        chk("t5_addr", mem_addr, 10'h030);
        tick;
        chk("t5_en2", mem_enable, 2'b01);
        tick;
        chk("t5_rdy", core_ready_sig, 4'b0010);
        chk("t5_rd", core_rd_data, ref_mem[10'h030]);
        set_slot(1, 2'b00, 0, 0);
        tick;
        tick;
        chk("t5_noserve_en", mem_enable, 2'b00);
        chk("t5_noserve_rdy", core_ready_sig, 0);
        chk("t5_sticky", err, 1);
        set_slot(3, 2'b00, 0, 0);
        tick;
        chk("t5_sticky2", err, 1);
        do_reset;
        chk("t5_err_clr", err, 0);
        // randomized transactions against the model
        for (int t = 0; t < 80; t++) begin
            scramble;
            for (int s = 0; s < CC; s++) reqv[s] = core_enable[2*s +: 2] != 2'b00;
            w = rr(reqv, last);
            ack_delay = $urandom_range(0, 3);
            if (w >= 0) begin
                op = core_enable[2*w +: 2];
                a = core_addr[AW*w +: AW];
                d = core_wr_data[RW*w +: RW];
            end
            tick;
            if (w < 0) begin
                chk("rnd_idle_en", mem_enable, 2'b00);
                chk("rnd_idle_rdy", core_ready_sig, 0);
                continue;
            end
            for (int j = 0; j <= ack_delay; j++) begin
                chk("rnd_en", mem_enable, op);
                chk("rnd_addr", mem_addr, a);
                chk("rnd_wr", mem_wr_data, d);
                chk("rnd_rdy0", core_ready_sig, 0);
                scramble;
                tick;
            end
            if (op == 2'b01) rd_exp = ref_mem[a];
            else ref_mem[a] = d;
            chk("rnd_rdy", core_ready_sig, 64'(1) << w);
            chk("rnd_rd", core_rd_data, rd_exp);
            last = w;
            tick;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
